// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-subsystem definitions (main_memory, cache_l1)
//
// Contents:
//   WORD_W            data word width in bits
//   CNT_W             width of the wait-cycle counter
//   ERR_WORD          data returned by a read of an out-of-range address
//   word_t            one data word
//   mem_state_e       access sequencer states IDLE / WAIT / DONE
//   addr_out_of_range true when a byte address is misaligned or above the array

package mem_pkg;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 4;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t ERR_WORD = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_e;

   // aw is the word-address width; valid byte addresses are word aligned
   // and lie below 4 * 2**aw.
   function automatic logic addr_out_of_range(input logic [31:0] addr,
                                              input int unsigned aw);
      return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/mem_array_sp.sv
// rtl/mem_array_sp.sv - single-port word array, synchronous write, registered read
//
// Parameters:
//   ADDR_WIDTH  word-address bits, depth 2**ADDR_WIDTH
//   INIT_BASE   word i powers up holding INIT_BASE + i
// Ports:
//   clk      clock, all logic on posedge
//   i_we     write enable, stores i_wdata at i_addr
//   i_re     read enable, registers word at i_addr into o_rdata
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data (holds between reads)
// Contents are never reset.

module mem_array_sp
   import mem_pkg::*;
#(
   parameter int    ADDR_WIDTH = 8,
   parameter word_t INIT_BASE  = 32'h1000_0000
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  word_t                 i_wdata,
   output word_t                 o_rdata
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   word_t w_words [DEPTH];
   word_t r_rdata;

   // One register per word so each can carry its own power-up value.
   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      word_t r_word = INIT_BASE + WORD_W'(g);

      always_ff @(posedge clk) begin
         if (i_we && (i_addr == ADDR_WIDTH'(g))) begin
            r_word <= i_wdata;
         end
      end

      assign w_words[g] = r_word;
   end

   always_ff @(posedge clk) begin
      if (i_re) begin
         r_rdata <= w_words[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/main_memory.sv
// rtl/main_memory.sv - fixed-latency word memory with a ce/rw/ready handshake
//
// Parameters:
//   ADDR_WIDTH  word-address bits (depth 2**ADDR_WIDTH words of 32 bits)
//   LAT         wait cycles inserted per access (0..15)
//   INIT_BASE   word i powers up holding INIT_BASE + i
// Ports:
//   clk        clock, all logic on posedge
//   rst        asynchronous active-low reset
//   mem_ce     access request, held by the requester until mem_ready
//   mem_rw     1 = read, 0 = write
//   mem_addr   byte address, word index = mem_addr[ADDR_WIDTH+1:2]
//   mem_data   bidirectional data; driven here only in the DONE cycle of a read
//   mem_ready  one-cycle completion pulse
//   mem_busy   high from acceptance to the end of the mem_ready cycle
//   mem_err    (MAIN_MEMORY_RANGE_CHECK_EN only) pulses with mem_ready when the
//              accepted address was misaligned or above the array
// Build option:
//   MAIN_MEMORY_RANGE_CHECK_EN  adds mem_err; erroring writes are dropped and
//                               erroring reads return ERR_WORD. Without it the
//                               low and high address bits are simply ignored.

module main_memory
   import mem_pkg::*;
#(
   parameter int    ADDR_WIDTH = 8,
   parameter int    LAT        = 3,
   parameter word_t INIT_BASE  = 32'h1000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_ce,
   input  logic              mem_rw,
   input  logic [31:0]       mem_addr,
   inout  wire  [WORD_W-1:0] mem_data,
   output logic              mem_ready,
   output logic              mem_busy
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
   ,
   output logic              mem_err
`endif
);

   mem_state_e            r_state;
   mem_state_e            w_next_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic                  r_rw;
   logic                  r_err;
   word_t                 r_wdata;
   word_t                 w_rdata;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_acc_err;

   assign w_accept = (r_state == IDLE) && mem_ce;
   // Final WAIT cycle: the array is written or read on this edge.
   assign w_last   = (r_state == WAIT) && (r_cnt == '0);

`ifdef MAIN_MEMORY_RANGE_CHECK_EN
   assign w_acc_err = addr_out_of_range(mem_addr, ADDR_WIDTH);
   assign mem_err   = mem_ready && r_err;
`else
   logic w_unused_addr;
   assign w_acc_err     = 1'b0;
   assign w_unused_addr = ^{mem_addr[1:0], mem_addr[31:ADDR_WIDTH+2]};
`endif

   // State register and wait counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_cnt <= CNT_W'(LAT);
         end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   // Request capture: everything the access needs is frozen at acceptance,
   // so later changes on the bus have no effect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx   <= '0;
         r_rw    <= 1'b0;
         r_wdata <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_idx <= mem_addr[ADDR_WIDTH+1:2];
         r_rw  <= mem_rw;
         r_err <= w_acc_err;
         if (!mem_rw) begin
            r_wdata <= mem_data;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      mem_ready    = 1'b0;
      mem_busy     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (mem_ce) begin
               w_next_state = WAIT;
            end
         end
         WAIT: begin
            mem_busy = 1'b1;
            if (r_cnt == '0) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            mem_busy     = 1'b1;
            mem_ready    = 1'b1;
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   mem_array_sp #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_BASE  (INIT_BASE)
   ) u_array (
      .clk     (clk),
      .i_we    (w_last && !r_rw && !r_err),
      .i_re    (w_last && r_rw),
      .i_addr  (r_idx),
      .i_wdata (r_wdata),
      .o_rdata (w_rdata)
   );

   // Bus is driven only in the DONE cycle of a read; reset forces IDLE and
   // therefore releases it immediately.
   assign mem_data = (mem_ready && r_rw) ? (r_err ? ERR_WORD : w_rdata)
                                         : {WORD_W{1'bz}};

endmodule

// File: tb/tb_main_memory.sv
// tb/tb_main_memory.sv - self-checking bench for main_memory (LAT=3 and LAT=0 instances)
module tb_main_memory;

   localparam int          AW    = 8;
   localparam int          LAT_A = 3;
   localparam int          LAT_B = 0;
   localparam logic [31:0] BASE  = 32'h1000_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]  ce, rw, oe;
   logic [31:0] addr0, addr1, drv0, drv1;
   wire  [31:0] bus0, bus1;
   wire         ready0, ready1, busy0, busy1;

   assign bus0 = oe[0] ? drv0 : 'z;
   assign bus1 = oe[1] ? drv1 : 'z;

`ifdef MAIN_MEMORY_RANGE_CHECK_EN
   wire err0, err1;
`endif

   main_memory #(.ADDR_WIDTH(AW), .LAT(LAT_A), .INIT_BASE(BASE)) u_mem0 (
      .clk       (clk),
      .rst       (rst),
      .mem_ce    (ce[0]),
      .mem_rw    (rw[0]),
      .mem_addr  (addr0),
      .mem_data  (bus0),
      .mem_ready (ready0),
      .mem_busy  (busy0)
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
      ,
      .mem_err   (err0)
`endif
   );

   main_memory #(.ADDR_WIDTH(AW), .LAT(LAT_B), .INIT_BASE(BASE)) u_mem1 (
      .clk       (clk),
      .rst       (rst),
      .mem_ce    (ce[1]),
      .mem_rw    (rw[1]),
      .mem_addr  (addr1),
      .mem_data  (bus1),
      .mem_ready (ready1),
      .mem_busy  (busy1)
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
      ,
      .mem_err   (err1)
`endif
   );

   int sel;
   wire        s_ready = (sel == 1) ? ready1 : ready0;
   wire        s_busy  = (sel == 1) ? busy1  : busy0;
   wire [31:0] s_bus   = (sel == 1) ? bus1   : bus0;
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
   wire        s_err   = (sel == 1) ? err1   : err0;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] model [2][256];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic c, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic o);
      if (sel == 1) begin
         ce[1] = c; rw[1] = r; addr1 = a; drv1 = d; oe[1] = o;
      end else begin
         ce[0] = c; rw[0] = r; addr0 = a; drv0 = d; oe[0] = o;
      end
   endtask

   // One access; after the acceptance edge the bus inputs are replaced by
   // (r2, a2, d2) and mem_ce is dropped, neither of which may affect it.
   task automatic do_access(input logic r, input logic [31:0] a, input logic [31:0] d,
                            input logic r2, input logic [31:0] a2, input logic [31:0] d2,
                            output logic [31:0] rdata, output logic err_o);
      int lat;
      int exp_lat;
      exp_lat = (sel == 1) ? LAT_B + 1 : LAT_A + 1;
      @(negedge clk);
      set_in(1'b1, r, a, d, !r);
      @(posedge clk); #1;
      check("busy_at_accept", 32'(s_busy), 32'd1);
      set_in(1'b0, r2, a2, d2, 1'b0);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (s_ready) break;
      end
      rdata = s_bus;
      err_o = 1'b0;
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
      err_o = s_err;
`endif
      check("latency", 32'(lat), 32'(exp_lat));
      check("busy_in_done", 32'(s_busy), 32'd1);
      @(posedge clk); #1;
      check("ready_fall", 32'(s_ready), 32'd0);
      check("busy_fall", 32'(s_busy), 32'd0);
   endtask

   // Access checked against the reference model.
   task automatic ref_txn(input logic r, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] a2, input string tag);
      logic [31:0] rd;
      logic        e;
      logic        exp_err;
      int          idx;
      idx     = int'((a / 4) % 256);
      exp_err = 1'b0;
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
      exp_err = ((a % 4) != 0) || (a >= 32'd1024);
`endif
      do_access(r, a, d, !r, a2, ~d, rd, e);
      if (r) check(tag, rd, exp_err ? 32'hDEAD_BEEF : model[sel][idx]);
      else if (!exp_err) model[sel][idx] = d;
      check({tag, "_err"}, 32'(e), 32'(exp_err));
   endtask

   initial begin
      logic [31:0] rd;
      logic        e;
      logic        seen;
      logic [31:0] a;

      for (int m = 0; m < 2; m++)
         for (int i = 0; i < 256; i++)
            model[m][i] = BASE + 32'(i);

      rst = 1'b0;
      ce = '0; rw = '0; oe = '0;
      addr0 = '0; addr1 = '0; drv0 = '0; drv1 = '0;
      sel = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready0", 32'(ready0), 32'd0);
      check("rst_busy0", 32'(busy0), 32'd0);
      check("rst_ready1", 32'(ready1), 32'd0);
      check("rst_busy1", 32'(busy1), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Read 0x20 with LAT=3; bus must be released while idle.
      sel = 0;
      @(negedge clk);
      set_in(1'b0, 1'b1, 32'h0, 32'hA5A5_5A5A, 1'b1);
      #1 check("idle_bus_free", s_bus, 32'hA5A5_5A5A);
      set_in(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      do_access(1'b1, 32'h20, 32'h0, 1'b1, 32'h20, 32'h0, rd, e);
      check("rd_0x20", rd, 32'h1000_0008);
      @(negedge clk);
      set_in(1'b0, 1'b1, 32'h0, 32'h3C3C_C3C3, 1'b1);
      #1 check("post_read_bus_free", s_bus, 32'h3C3C_C3C3);
      set_in(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);

      // Write then read back, neighbour untouched.
      do_access(1'b0, 32'h44, 32'hCAFE_0001, 1'b1, 32'h40, 32'h0, rd, e);
      model[0][17] = 32'hCAFE_0001;
      do_access(1'b1, 32'h44, 32'h0, 1'b1, 32'h44, 32'h0, rd, e);
      check("rd_0x44", rd, 32'hCAFE_0001);
      do_access(1'b1, 32'h40, 32'h0, 1'b1, 32'h40, 32'h0, rd, e);
      check("rd_0x40", rd, 32'h1000_0010);

      // Address changed one cycle after acceptance.
      do_access(1'b1, 32'h20, 32'h0, 1'b1, 32'h24, 32'h0, rd, e);
      check("addr_change", rd, 32'h1000_0008);

      // Reset during WAIT of a write discards it.
      @(negedge clk);
      set_in(1'b1, 1'b0, 32'h10, 32'h1234_5678, 1'b1);
      @(posedge clk); #1;
      set_in(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("async_rst_busy", 32'(s_busy), 32'd0);
      check("async_rst_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (s_ready || s_busy) seen = 1'b1;
      end
      check("rst_no_ready", 32'(seen), 32'd0);
      do_access(1'b1, 32'h10, 32'h0, 1'b1, 32'h10, 32'h0, rd, e);
      check("rd_0x10_after_rst", rd, 32'h1000_0004);

      // LAT=0, mem_ce held high: back-to-back every 3 cycles.
      sel = 1;
      @(negedge clk);
      set_in(1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
      @(posedge clk); #1;
      check("b2b_busy_e0", 32'(s_busy), 32'd1);
      check("b2b_ready_e0", 32'(s_ready), 32'd0);
      @(posedge clk); #1;
      check("b2b_ready_e1", 32'(s_ready), 32'd1);
      check("b2b_data_e1", s_bus, 32'h1000_0000);
      @(posedge clk); #1;
      check("b2b_idle_e2", 32'({s_busy, s_ready}), 32'd0);
      @(posedge clk); #1;
      check("b2b_accept_e3", 32'(s_busy), 32'd1);
      set_in(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      @(posedge clk); #1;
      check("b2b_ready_e4", 32'(s_ready), 32'd1);
      check("b2b_data_e4", s_bus, 32'h1000_0000);
      @(posedge clk); #1;

`ifdef MAIN_MEMORY_RANGE_CHECK_EN
      sel = 0;
      do_access(1'b1, 32'h22, 32'h0, 1'b1, 32'h22, 32'h0, rd, e);
      check("err_rd_data", rd, 32'hDEAD_BEEF);
      check("err_rd_flag", 32'(e), 32'd1);
      do_access(1'b0, 32'h400, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h0, rd, e);
      check("err_wr_flag", 32'(e), 32'd1);
      do_access(1'b1, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, rd, e);
      check("err_wr_no_change", rd, 32'h1000_0000);
      check("ok_rd_flag", 32'(e), 32'd0);
`endif

      // Randomized traffic on both instances against the model.
      for (int s = 0; s < 2; s++) begin
         sel = s;
         for (int n = 0; n < 30; n++) begin
            a = $urandom;
`ifdef MAIN_MEMORY_RANGE_CHECK_EN
            if ($urandom_range(3) != 0) a = (a % 256) * 4;
`endif
            if ($urandom_range(2) == 0) a = (a % 16) * 4;
            ref_txn(1'($urandom), a, $urandom, $urandom, "rand");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning word-address bits (depth 2**ADDR_WIDTH words of 32 bits).
REQ-002 The block SHALL have parameter LAT, default 3, meaning wait cycles inserted per access (0..15).
REQ-003 The block SHALL have parameter INIT_BASE, default 32'h1000_0000, meaning word i holds INIT_BASE+i at elaboration.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port mem_ce, input, 1 bit: access request, held by requester until mem_ready.
REQ-007 The block SHALL have port mem_rw, input, 1 bit: 1=read, 0=write.
REQ-008 The block SHALL have port mem_addr, input, 32 bits: byte address; word index = mem_addr[ADDR_WIDTH+1:2].
REQ-009 The block SHALL have port mem_data, inout, 32 bits: driven by the requester on writes and by this block on read completion only, otherwise Z from this block.
REQ-010 The block SHALL have port mem_ready, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port mem_busy, output, 1 bit: high from acceptance until the end of the mem_ready cycle.

Function
REQ-012 The block SHALL implement FSM states IDLE, WAIT, DONE.
REQ-013 In IDLE, on a posedge with mem_ce=1, the block SHALL latch the word index, mem_rw and, if writing, mem_data; load the counter with LAT; and go to WAIT.
REQ-014 In WAIT, the block SHALL decrement the counter each cycle and go to DONE on the edge where the counter equals 0; LAT=0 SHALL give one WAIT cycle.
REQ-015 For a write, the latched data SHALL be stored into the array on the WAIT->DONE edge.
REQ-016 For a read, the array word SHALL be registered on the WAIT->DONE edge and driven on mem_data only while in DONE.
REQ-017 In DONE, mem_ready SHALL be 1; the block SHALL return to IDLE unconditionally on the next edge.
REQ-018 Acceptance-edge to mem_ready-high latency SHALL be LAT+1 cycles; mem_ready SHALL fall after exactly one cycle.
REQ-019 If mem_ce is still 1 in IDLE after DONE, a new access SHALL be accepted: back-to-back throughput is one access per LAT+3 cycles.
REQ-020 Changes on mem_addr, mem_rw or mem_data after acceptance SHALL be ignored for that access.
REQ-021 A mem_ce deassert during WAIT SHALL NOT abort the access; it SHALL complete normally.
REQ-022 mem_addr[1:0] and bits above ADDR_WIDTH+1 SHALL be ignored, except as given in REQ-027.

Reset
REQ-023 On rst=0, the FSM SHALL go to IDLE and the counter to 0, with mem_ready=0, mem_busy=0, and mem_data released to Z, immediately and asynchronously.
REQ-024 Reset during WAIT SHALL discard the pending access: no array write and no mem_ready.
REQ-025 Array contents SHALL NOT be affected by reset.
REQ-026 The block SHALL leave reset synchronously on the first posedge with rst=1, in IDLE.

Configuration
REQ-027 With macro MAIN_MEMORY_RANGE_CHECK_EN defined, the block SHALL add output mem_err (1 bit, reset 0), pulsed together with mem_ready when the accepted address has nonzero [1:0] or nonzero bits above ADDR_WIDTH+1; an erroring write SHALL NOT modify the array, and an erroring read SHALL drive 32'hDEAD_BEEF.
REQ-028 Without MAIN_MEMORY_RANGE_CHECK_EN, the mem_err port SHALL be absent and addresses SHALL be wrapped as in REQ-022.

Structure
REQ-029 The state enum (IDLE/WAIT/DONE), the 32-bit word width, and the DEAD_BEEF error constant SHALL reside in shared package mem_pkg, which is also used by cache_l1.
REQ-030 The storage SHALL be a sub-module mem_array_sp: single-port, synchronous write, registered read, depth 2**ADDR_WIDTH; the FSM, counter and tristate SHALL be in main_memory.

Verification
REQ-031 Scenario: after reset, read 0x20 with LAT=3 -> mem_busy from the acceptance edge, mem_ready 4 cycles later for 1 cycle, mem_data=0x1000_0008 in that cycle and Z otherwise.
REQ-032 Scenario: write 0xCAFE_0001 to 0x44, then read 0x44 -> read returns 0xCAFE_0001; neighbour 0x40 still reads 0x1000_0010.
REQ-033 Scenario: LAT=0 read of 0x0 -> mem_ready 1 cycle after acceptance; mem_ce held high continuously -> second acceptance exactly 3 cycles after the first.
REQ-034 Scenario: rst pulsed low mid-WAIT on a write of 0x1234_5678 to 0x10 -> mem_ready never pulses; a later read of 0x10 returns 0x1000_0004.
REQ-035 Scenario: mem_addr changed from 0x20 to 0x24 one cycle after acceptance -> data from 0x20 returned.
REQ-036 Scenario: with MAIN_MEMORY_RANGE_CHECK_EN, read 0x22 -> mem_err=1 with mem_ready and data 0xDEAD_BEEF; write to 0x400 (ADDR_WIDTH=8) -> mem_err=1 and array unchanged.
